// File: rtl/fft_out_reorder_if.sv
// Stream bundle around the FFT output reorder buffer: bit-reversed FFT samples in, natural-order samples out.
// Latency: none; this file only groups wires.
// Backpressure: finish_i cannot be stalled; valid_o/ready_i handshake on the natural-order side.
// Optional port mag_o exists only when FFT_REORDER_MAG_EN is defined.
interface fft_out_reorder_if #(
    parameter int LOGN = 5,
    parameter int DW   = 18
);
    logic            finish_i;
    logic [DW-1:0]   X_r_i;
    logic [DW-1:0]   X_i_i;
    logic            valid_o;
    logic            ready_i;
    logic [DW-1:0]   Y_r;
    logic [DW-1:0]   Y_i;
    logic [LOGN-1:0] index_o;
    logic            last_o;
    logic            overflow_o;
`ifdef FFT_REORDER_MAG_EN
    logic [DW:0]     mag_o;

    modport slave (
        input  finish_i, X_r_i, X_i_i, ready_i,
        output valid_o, Y_r, Y_i, index_o, last_o, overflow_o, mag_o
    );

    modport master (
        output finish_i, X_r_i, X_i_i, ready_i,
        input  valid_o, Y_r, Y_i, index_o, last_o, overflow_o, mag_o
    );
`else
    modport slave (
        input  finish_i, X_r_i, X_i_i, ready_i,
        output valid_o, Y_r, Y_i, index_o, last_o, overflow_o
    );

    modport master (
        output finish_i, X_r_i, X_i_i, ready_i,
        input  valid_o, Y_r, Y_i, index_o, last_o, overflow_o
    );
`endif
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: captures bit-reversed FFT frames, replays them in natural index order.
// Latency: first output valid the cycle after the last sample of a frame is captured; Y is read combinationally.
// Backpressure: ready_i stalls the replay; a sample arriving while both banks are full is dropped (sticky overflow_o).
// Optional: define FFT_REORDER_MAG_EN to add mag_o = |Y_r| + |Y_i|.
module fft_out_reorder #(
    parameter int N    = 32,
    parameter int LOGN = 5,
    parameter int DW   = 18
) (
    input  logic          clk,
    input  logic          rst,
    fft_out_reorder_if.slave bus
);
    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [LOGN-1:0] CNT_LAST = LOGN'(N - 1);

    state_t          state, state_nxt;
    logic [2*DW-1:0] mem [2][N];
    logic [1:0]      full, full_nxt;
    logic            wr_bank, rd_bank;
    logic [LOGN-1:0] wr_cnt, rd_cnt;
    logic            overflow;
    logic            wr_en, wr_done, rd_fire, rd_done;
    logic [2*DW-1:0] rd_word;
    logic [DW-1:0]   y_r, y_i;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
        return r;
    endfunction

    // Handshake qualifiers; the write side only sees the registered full flag,
    // so a bank freed by the reader this cycle becomes writable next cycle.
    always_comb begin
        wr_en   = bus.finish_i && !full[wr_bank];
        wr_done = wr_en && (wr_cnt == CNT_LAST);
        rd_fire = (state == STREAM) && bus.ready_i;
        rd_done = rd_fire && (rd_cnt == CNT_LAST);
    end

    // Per-bank full flags: writer completion sets, reader completion clears, independently.
    always_comb begin
        full_nxt = full;
        if (wr_done) full_nxt[wr_bank] = 1'b1;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
    end

    // Reader FSM; looks at next-cycle full flags so a frame completing this edge
    // streams immediately and back-to-back frames run without a bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full_nxt[rd_bank]) state_nxt = STREAM;
            STREAM:  if (rd_done) state_nxt = full_nxt[~rd_bank] ? STREAM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pointers, flags, FSM state and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            full  <= full_nxt;
            if (wr_en) begin
                wr_cnt <= wr_done ? '0 : wr_cnt + 1'b1;
                if (wr_done) wr_bank <= ~wr_bank;
            end
            if (bus.finish_i && full[wr_bank]) overflow <= 1'b1;
            if (rd_fire) begin
                rd_cnt <= rd_done ? '0 : rd_cnt + 1'b1;
                if (rd_done) rd_bank <= ~rd_bank;
            end
        end
    end

    // Sample storage, written at the bit-reversed address; contents need no reset
    // because a bank is only read after a complete frame has been written to it.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][bitrev(wr_cnt)] <= {bus.X_r_i, bus.X_i_i};
    end

    // Natural-order output; data forced to zero while nothing is being offered.
    always_comb begin
        rd_word        = mem[rd_bank][rd_cnt];
        y_r            = (state == STREAM) ? rd_word[2*DW-1:DW] : '0;
        y_i            = (state == STREAM) ? rd_word[DW-1:0]    : '0;
        bus.valid_o    = (state == STREAM);
        bus.Y_r        = y_r;
        bus.Y_i        = y_i;
        bus.index_o    = rd_cnt;
        bus.last_o     = (state == STREAM) && (rd_cnt == CNT_LAST);
        bus.overflow_o = overflow;
    end

`ifdef FFT_REORDER_MAG_EN
    logic [DW-1:0] abs_r, abs_i;

    // L1 magnitude; an unsigned DW-bit magnitude holds 2^(DW-1) exactly, so no wrap.
    always_comb begin
        abs_r     = y_r[DW-1] ? (~y_r + 1'b1) : y_r;
        abs_i     = y_i[DW-1] ? (~y_i + 1'b1) : y_i;
        bus.mag_o = {1'b0, abs_r} + {1'b0, abs_i};
    end
`endif
endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: table-driven single frame, directed corner sequences, randomized run vs frame model.
// Latency: checks first valid one cycle after the last captured sample.
// Backpressure: exercises ready_i stalls, back-to-back frames and dropped-sample overflow.
module tb_fft_out_reorder;
    localparam int N    = 32;
    localparam int LOGN = 5;
    localparam int DW   = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_out_reorder_if #(.LOGN(LOGN), .DW(DW)) bus ();
    fft_out_reorder #(.N(N), .LOGN(LOGN), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] xr;
        logic [DW-1:0] xi;
        int            exp_yr;
        int            exp_yi;
        int            exp_idx;
        bit            exp_last;
    } vec_t;

    vec_t tbl [N];

    function automatic int brev(input int v);
        int r = 0;
        for (int b = 0; b < LOGN; b++) if (v[b]) r |= (1 << (LOGN - 1 - b));
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.finish_i = 1'b0;
        bus.ready_i  = 1'b0;
        bus.X_r_i    = '0;
        bus.X_i_i    = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic put(input logic [DW-1:0] xr, input logic [DW-1:0] xi);
        bus.finish_i = 1'b1;
        bus.X_r_i    = xr;
        bus.X_i_i    = xi;
        tick();
        bus.finish_i = 1'b0;
    endtask

    // Frame f carries X_r = 100*f + bitrev(j), X_i = -bitrev(j).
    task automatic feed(input int first, input int count);
        for (int f = first; f < first + count; f++)
            for (int j = 0; j < N; j++)
                put(DW'(100 * f + brev(j)), DW'(-brev(j)));
    endtask

    // Consume nout samples; output k must be frame k/N, index k%N.
    task automatic drain(input int nout, input int stall_at, input int stall_len, output int bubbles);
        int  k = 0;
        int  stall = 0;
        int  waited = 0;
        int  pos;
        bit  rdy;
        bubbles = 0;
        bus.ready_i = 1'b1;
        while (!bus.valid_o && waited < 200) begin
            tick();
            waited++;
        end
        chk("drain_start_valid", 64'(bus.valid_o), 64'(1));
        for (int cyc = 0; cyc < 2 * nout + stall_len + 50 && k < nout; cyc++) begin
            rdy = 1'b1;
            if (!bus.valid_o) begin
                bubbles++;
            end else begin
                pos = k % N;
                chk("drain_idx",  64'(bus.index_o), 64'(pos));
                chk("drain_yr",   64'($signed(bus.Y_r)), 64'(100 * (k / N) + pos));
                chk("drain_yi",   64'($signed(bus.Y_i)), 64'(-pos));
                chk("drain_last", 64'(bus.last_o), 64'(pos == N - 1));
                if (pos == stall_at && stall < stall_len) begin
                    rdy = 1'b0;
                    stall++;
                end
            end
            bus.ready_i = rdy;
            if (bus.valid_o && rdy) k++;
            tick();
        end
        chk("drain_count", 64'(k), 64'(nout));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bub;
        int  waited;
        int  c;
        int  opos;
        bit  ovf_m;
        bit  fin, rdy, hs;
        int  inc, dec;
        logic [DW-1:0] xr, xi;
        logic [DW-1:0] cur_r[$], cur_i[$], exp_r[$], exp_i[$];
        logic [DW-1:0] nat_r [N];
        logic [DW-1:0] nat_i [N];

        // ---------------- single frame, table driven ----------------
        for (int k = 0; k < N; k++) begin
            tbl[k].xr       = DW'(brev(k));
            tbl[k].xi       = DW'(-brev(k));
            tbl[k].exp_yr   = k;
            tbl[k].exp_yi   = -k;
            tbl[k].exp_idx  = k;
            tbl[k].exp_last = (k == N - 1);
        end

        do_reset();
        chk("rst_valid", 64'(bus.valid_o), 64'(0));
        chk("rst_index", 64'(bus.index_o), 64'(0));
        chk("rst_last",  64'(bus.last_o), 64'(0));
        chk("rst_ovf",   64'(bus.overflow_o), 64'(0));
        chk("rst_yr",    64'(bus.Y_r), 64'(0));

        bus.ready_i = 1'b1;
        for (int k = 0; k < N; k++) begin
            put(tbl[k].xr, tbl[k].xi);
            if (k == N - 2) chk("tbl_early_valid", 64'(bus.valid_o), 64'(0));
        end
        chk("tbl_first_valid", 64'(bus.valid_o), 64'(1));
        for (int k = 0; k < N; k++) begin
            chk("tbl_valid", 64'(bus.valid_o), 64'(1));
            chk("tbl_yr",    64'($signed(bus.Y_r)), 64'(tbl[k].exp_yr));
            chk("tbl_yi",    64'($signed(bus.Y_i)), 64'(tbl[k].exp_yi));
            chk("tbl_idx",   64'(bus.index_o), 64'(tbl[k].exp_idx));
            chk("tbl_last",  64'(bus.last_o), 64'(tbl[k].exp_last));
            tick();
        end
        chk("tbl_end_valid", 64'(bus.valid_o), 64'(0));
        chk("tbl_end_ovf",   64'(bus.overflow_o), 64'(0));

        // ---------------- backpressure at index 5 ----------------
        do_reset();
        bus.ready_i = 1'b1;
        feed(0, 1);
        drain(N, 5, 10, bub);
        chk("bp_no_bubble", 64'(bub), 64'(0));

        // ---------------- back-to-back frames ----------------
        do_reset();
        fork
            feed(0, 2);
            drain(2 * N, -1, 0, bub);
        join
        chk("b2b_no_bubble", 64'(bub), 64'(0));

        // ---------------- overflow ----------------
        do_reset();
        feed(0, 2);
        chk("ovf_before", 64'(bus.overflow_o), 64'(0));
        put(DW'(200 + brev(0)), DW'(-brev(0)));
        chk("ovf_first_drop", 64'(bus.overflow_o), 64'(1));
        for (int j = 1; j < N; j++) put(DW'(200 + brev(j)), DW'(-brev(j)));
        drain(2 * N, -1, 0, bub);
        for (int i = 0; i < 5; i++) tick();
        chk("ovf_no_third_frame", 64'(bus.valid_o), 64'(0));
        chk("ovf_sticky", 64'(bus.overflow_o), 64'(1));

        // ---------------- reset mid-frame and mid-output ----------------
        do_reset();
        for (int j = 0; j < 12; j++) put(DW'(brev(j) + 7), DW'(3));
        rst = 1'b1;
        #2;
        chk("rst_mid_in_valid", 64'(bus.valid_o), 64'(0));
        tick();
        rst = 1'b0;
        feed(0, 1);
        drain(N, -1, 0, bub);

        feed(0, 1);
        bus.ready_i = 1'b1;
        waited = 0;
        while (!(bus.valid_o && bus.index_o == LOGN'(7)) && waited < 100) begin
            tick();
            waited++;
        end
        chk("rst_mid_out_reach7", 64'(bus.index_o), 64'(7));
        rst = 1'b1;
        #2;
        chk("rst_mid_out_valid", 64'(bus.valid_o), 64'(0));
        chk("rst_mid_out_index", 64'(bus.index_o), 64'(0));
        chk("rst_mid_out_last",  64'(bus.last_o), 64'(0));
        tick();
        rst = 1'b0;
        feed(0, 1);
        drain(N, -1, 0, bub);

`ifdef FFT_REORDER_MAG_EN
        // ---------------- L1 magnitude ----------------
        do_reset();
        bus.ready_i = 1'b1;
        for (int j = 0; j < N; j++) begin
            if (j == 0)       put(DW'(-(1 << (DW - 1))), DW'((1 << (DW - 1)) - 1));
            else if (j == 16) put(DW'(3), DW'(-4));
            else              put(DW'(0), DW'(0));
        end
        chk("mag_extreme", 64'(bus.mag_o), 64'(262143));
        tick();
        chk("mag_idx1", 64'(bus.index_o), 64'(1));
        chk("mag_small", 64'(bus.mag_o), 64'(7));
        for (int i = 0; i < N; i++) tick();
`endif

        // ---------------- randomized run vs frame-level model ----------------
        do_reset();
        c = 0;
        opos = 0;
        ovf_m = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_valid", 64'(bus.valid_o), 64'(c > 0));
            chk("rnd_ovf",   64'(bus.overflow_o), 64'(ovf_m));
            if (c > 0 && bus.valid_o) begin
                chk("rnd_yr",   64'($signed(bus.Y_r)), 64'($signed(exp_r[0])));
                chk("rnd_yi",   64'($signed(bus.Y_i)), 64'($signed(exp_i[0])));
                chk("rnd_idx",  64'(bus.index_o), 64'(opos));
                chk("rnd_last", 64'(bus.last_o), 64'(opos == N - 1));
            end
            fin = ($urandom_range(0, 9) < 8);
            if ((cyc / 500) % 2 == 0) rdy = ($urandom_range(0, 9) < 9);
            else                      rdy = ($urandom_range(0, 9) < 3);
            xr = DW'($urandom);
            xi = DW'($urandom);

            // Model for the coming edge: at most two complete frames can be held.
            inc = 0;
            dec = 0;
            hs  = (c > 0) && rdy;
            if (fin) begin
                if (c < 2) begin
                    cur_r.push_back(xr);
                    cur_i.push_back(xi);
                    if (cur_r.size() == N) begin
                        for (int j = 0; j < N; j++) begin
                            nat_r[brev(j)] = cur_r[j];
                            nat_i[brev(j)] = cur_i[j];
                        end
                        for (int i = 0; i < N; i++) begin
                            exp_r.push_back(nat_r[i]);
                            exp_i.push_back(nat_i[i]);
                        end
                        cur_r.delete();
                        cur_i.delete();
                        inc = 1;
                    end
                end else begin
                    ovf_m = 1'b1;
                end
            end
            if (hs) begin
                void'(exp_r.pop_front());
                void'(exp_i.pop_front());
                opos++;
                if (opos == N) begin
                    opos = 0;
                    dec = 1;
                end
            end
            c = c + inc - dec;

            bus.finish_i = fin;
            bus.X_r_i    = xr;
            bus.X_i_i    = xi;
            bus.ready_i  = rdy;
            tick();
        end
        bus.finish_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
